// File: rtl/cpu_pkg.sv
// Types and widths shared by the CPU datapath and the data-RAM arbiter.
package cpu_pkg;

    localparam int RAM_AW = 10;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_PEND,
        ARB_ACK
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU (priority) and a host port.
// The host uses cycles the CPU leaves idle. After STARVE_LIMIT lost cycles,
// the CPU is held for one cycle so the host gets through.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ARB_IDLE | no host request latched; RAM follows the CPU
//   ARB_PEND | host request latched, waiting for an idle or forced cycle
//   ARB_ACK  | host access done; host_ack high for this one cycle
module ram_arbiter
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [RAM_DW-1:0] cpu_wdata,
    output logic [RAM_DW-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [RAM_AW-1:0] host_addr,
    input  logic [RAM_DW-1:0] host_wdata,
    output logic              host_ack,
    output logic [RAM_DW-1:0] host_rdata,
    output logic [RAM_AW-1:0] ram_address,
    output logic [RAM_DW-1:0] ram_data,
    output logic              ram_we,
    input  logic [RAM_DW-1:0] ram_q
);

    // A limit of 0 still needs a 1-bit counter; it simply stays at 0.
    localparam int WC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WC_W-1:0] LIMIT_C = WC_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic              hwe_q, hwe_d;
    logic [RAM_AW-1:0] haddr_q, haddr_d;
    logic [RAM_DW-1:0] hwdata_q, hwdata_d;
    logic [RAM_DW-1:0] hrdata_q, hrdata_d;
    logic              starved;
    logic              gnt;

    // Grant decision: host wins when the CPU is idle or the host has starved.
    always_comb begin
        starved = (wait_q == LIMIT_C);
        gnt     = (state_q == ARB_PEND) && (!cpu_req || starved);
    end

    // RAM port mux; writes are blocked while reset is asserted.
    always_comb begin
        if (gnt) begin
            ram_address = haddr_q;
            ram_data    = hwdata_q;
            ram_we      = hwe_q & nRESET;
        end else begin
            ram_address = cpu_addr;
            ram_data    = cpu_wdata;
            ram_we      = cpu_req & cpu_we & nRESET;
        end
        cpu_hold   = gnt & cpu_req;
        cpu_rdata  = ram_q;
        host_ack   = (state_q == ARB_ACK);
        host_rdata = hrdata_q;
    end

    // Next-state logic: latch the request, count lost cycles, capture read data.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        hwe_d    = hwe_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        hrdata_d = hrdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (host_req) begin
                    hwe_d    = host_we;
                    haddr_d  = host_addr;
                    hwdata_d = host_wdata;
                    wait_d   = '0;
                    state_d  = ARB_PEND;
                end
            end
            ARB_PEND: begin
                if (gnt) begin
                    hrdata_d = ram_q;
                    state_d  = ARB_ACK;
                end else if (!starved) begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State registers; reset drops any latched host request.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= ARB_IDLE;
            wait_q   <= '0;
            hwe_q    <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            hwe_q    <= hwe_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            hrdata_q <= hrdata_d;
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port 1024x8 data RAM between the CPU core and a host port (debug/DMA loader) without stalling the CPU in the common case. CPU accesses have priority. Host accesses use the RAM in cycles the CPU leaves idle. A starvation counter forces a one-cycle CPU hold when the host has waited too long. Sits between the CPU's RAM address/data/we nets and the `ram` instance.

## Interface
- STARVE_LIMIT, 8, PEND cycles lost to the CPU before the host is force-granted; 0 means the host always wins immediately.
- CLK  in  1  system clock; all state updates on the rising edge
- nRESET  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU reads or writes RAM this cycle (combinational from decode)
- cpu_we  in  1  CPU write strobe (level, valid with cpu_req)
- cpu_addr  in  10  {ADH[1:0],ADL}
- cpu_wdata  in  8  CPU write data (MEM)
- cpu_rdata  out  8  RAM read data to the CPU (= ram_q)
- cpu_hold  out  1  freeze the CPU this cycle (PC and register/PSW writes suppressed)
- host_req  in  1  host request, level; held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  10  host address
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  8  registered read data, valid while host_ack = 1
- ram_address  out  10  to RAM
- ram_data  out  8  to RAM
- ram_we  out  1  to RAM; the write occurs at the rising edge ending the cycle
- ram_q  in  8  RAM combinational read data

## Operation
- **States:** IDLE, PEND, ACK.
- **IDLE:**
  - host_req = 1 latches host_we, host_addr and host_wdata, clears wait_cnt, and moves to PEND.
  - Otherwise stays in IDLE.
- **Grant:** `gnt = (state==PEND) & (~cpu_req | starved)`, where `starved = (wait_cnt == STARVE_LIMIT)`. This is combinational within the same cycle.
- **RAM mux:**
  - When gnt = 1, the RAM is driven from the latched host request, and ram_we = latched host_we.
  - Otherwise the RAM is driven from the CPU, and ram_we = cpu_req & cpu_we.
- **cpu_hold** = gnt & cpu_req. The CPU is held only when force-granted. Its write is dropped and it re-executes the same instruction next cycle.
- **PEND with gnt = 1:** host_rdata <= ram_q (also captured on writes; value is don't-care to the host), then go to ACK.
- **PEND with gnt = 0:** CPU access proceeds. wait_cnt increments and saturates at STARVE_LIMIT.
- **ACK:** host_ack = 1 for exactly one cycle, then go to IDLE unconditionally.
  - Host must drop host_req in the ACK cycle.
  - A req still high in the following IDLE cycle is a new request.
- **cpu_rdata** = ram_q at all times.
- **wait_cnt:** width $clog2(STARVE_LIMIT+1), minimum 1 bit.

## Timing
- **Reset values:** state = IDLE, wait_cnt = 0, host_rdata = 0, host_ack = 0, cpu_hold = 0.
  - RAM port follows the CPU inputs combinationally.
  - ram_we = 0 while nRESET = 0.
- **Minimum host latency:** host_req sampled at edge 0, grant cycle 1, host_ack in cycle 2.
- **Maximum host latency:** STARVE_LIMIT + 2 cycles.
- **Reset mid-operation:** any latched request is discarded with no ack, and the host must re-request. A forced hold ends immediately.
- **Simultaneous cpu_req and PEND, not starved:** CPU wins and wait_cnt increments.
- **Starved, cpu_req = 0:** host is granted with no hold.
- **Host changing its inputs while in PEND:** ignored; the latched copy is used.
- **Address width:** 10 bits with no wrap logic; the address is passed through unchanged.

## Structure
- Shared package cpu_pkg holds:
  - `RAM_AW = 10`
  - `RAM_DW = 8`
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_PEND, ARB_ACK} arb_state_t`
- Flat module with no sub-module. The starvation counter and mux are too small to split out.
- The CPU top gates its PC/register `always_ff` enables with ~cpu_hold.

## Test plan
- **Idle CPU host write:** host write addr 0x155 data 0xA5 with cpu_req = 0.
  - Required: ram_we in cycle 1, host_ack in cycle 2.
  - A later host read of 0x155 returns host_rdata = 0xA5 with host_ack.
- **CPU priority:** CPU writes 0x3C to 0x010 every cycle with STARVE_LIMIT = 8 while the host read of 0x010 is pending.
  - Required: ram_address = 0x010 from the CPU for 8 PEND cycles, no hold.
  - Cycle 9: cpu_hold = 1, CPU write suppressed, host_rdata = 0x3C, ack the next cycle.
- **STARVE_LIMIT = 0:** host_req with cpu_req = 1.
  - Required: grant in the first PEND cycle with cpu_hold = 1, ack 2 cycles after req.
- **Back-to-back requests:** host_req held high through ACK.
  - Required: second access begins in the IDLE after ACK.
  - host_ack pulses exactly once per access, never on consecutive cycles.
- **Reset mid-operation:** nRESET asserted in PEND.
  - Required: state = IDLE, host_ack and cpu_hold low at once (asynchronously).
  - No RAM write from the discarded host request.
- **Read during hold:** cpu_rdata tracks ram_q in every cycle, including hold cycles.
